asip_controller: RTL and testbench

// - Single-cycle control unit of the 17-bit ASIP datapath; decodes Op = Instr[16:11] and Rd = Instr[7:4].
// - Drives datapath selects, register/memory write enables and the PC-select.
// - Holds a 4-bit NZCV flag register; evaluates branch conditions against the stored flags.

---
 rtl/asip_controller_if.sv | 40 ++++
 rtl/asip_controller.sv | 131 +++++++++++++
 tb/tb_asip_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/asip_controller_if.sv
// asip_controller_if
// Bundles the instruction fields, ALU flags and datapath control lines
// that pass between the ASIP datapath and its control unit.
//   slave  : the controller. Takes Op, Rd and ALUFlags; drives every control line.
//   master : the datapath. Drives Op, Rd and ALUFlags; takes every control line.
// Signals:
//   Op[5:0]         Instr[16:11]; [5:4] = class, [3:0] = class-specific subfield
//   Rd[3:0]         Instr[7:4], destination register field
//   ALUFlags[3:0]   {N,Z,C,V} from the ALU
//   RegSrc[1:0]     [0] = read PC on RA1, [1] = read Rd on RA2
//   RegWrite        register-file write enable
//   ImmSrc[1:0]     immediate extension select
//   ALUSrc          0 = register SrcB, 1 = extended immediate
//   ALUControl[1:0] 00 ADD, 01 SUB, 10 AND, 11 OR
//   MemWrite        data-memory write enable
//   MemtoReg        1 = write-back from memory
//   PCSrc           1 = next PC comes from the ALU result
interface asip_controller_if;
   logic [5:0] Op;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic [1:0] RegSrc;
   logic       RegWrite;
   logic [1:0] ImmSrc;
   logic       ALUSrc;
   logic [1:0] ALUControl;
   logic       MemWrite;
   logic       MemtoReg;
   logic       PCSrc;

   modport master (
      output Op, Rd, ALUFlags,
      input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc
   );

   modport slave (
      input  Op, Rd, ALUFlags,
      output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc
   );
endinterface

// File: rtl/asip_controller.sv
// asip_controller
// Single-cycle control unit for the 17-bit ASIP datapath. It decodes the
// opcode into datapath selects and write enables. It also keeps a 4-bit
// NZCV flag register, which compare (COM) instructions load and
// conditional branches test.
// Ports:
//   clk    rising edge loads the flag register when a COM executes
//   reset  asynchronous, active-high; clears the flag register to 0000
//   bus    asip_controller_if.slave: Op, Rd and ALUFlags in; all control lines out
// All outputs are purely combinational from Op, Rd and the stored flags.
// Configuration macro CONTROLLER_PCWRITE_EN: when it is defined, any
// register write to R15 (SUM, RST or CDM with Rd == 4'hF) also redirects
// the PC. When it is undefined, Rd is ignored and only branches drive PCSrc.
module asip_controller (
   input  logic            clk,
   input  logic            reset,
   asip_controller_if.slave bus
);

   localparam logic [1:0] CLS_DATA   = 2'b00;
   localparam logic [1:0] CLS_MEM    = 2'b01;
   localparam logic [1:0] CLS_BRANCH = 2'b10;

   localparam logic [1:0] CMD_SUM = 2'b00;
   localparam logic [1:0] CMD_RST = 2'b01;
   localparam logic [1:0] CMD_COM = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   logic [3:0] flags;
   logic       flagW;
   logic       isBranch;
   logic       condEx;
   logic       regWriteInt;
   logic       flagN, flagZ, flagV;
   logic       unusedBits;

   assign flagN = flags[3];
   assign flagZ = flags[2];
   assign flagV = flags[0];

   // Main decoder. Each field is read only in the class that gives it
   // meaning, so don't-care bits (including x/z) never reach the outputs.
   // Reserved encodings fall through to all-zero controls.
   always_comb begin
      bus.RegSrc     = 2'b00;
      regWriteInt    = 1'b0;
      bus.ImmSrc     = 2'b00;
      bus.ALUSrc     = 1'b0;
      bus.ALUControl = ALU_ADD;
      bus.MemWrite   = 1'b0;
      bus.MemtoReg   = 1'b0;
      flagW          = 1'b0;
      isBranch       = 1'b0;
      case (bus.Op[5:4])
         CLS_DATA: begin
            bus.ALUSrc = bus.Op[3];
            case (bus.Op[2:1])
               CMD_SUM: regWriteInt = 1'b1;
               CMD_RST: begin
                  regWriteInt    = 1'b1;
                  bus.ALUControl = ALU_SUB;
               end
               CMD_COM: begin
                  bus.ALUControl = ALU_SUB;
                  flagW          = 1'b1;
               end
               default: ;
            endcase
         end
         CLS_MEM: begin
            bus.ALUSrc = 1'b1;
            bus.ImmSrc = 2'b01;
            if (bus.Op[1]) begin
               regWriteInt  = 1'b1;
               bus.MemtoReg = 1'b1;
            end else begin
               bus.MemWrite = 1'b1;
               bus.RegSrc   = 2'b10;
            end
         end
         CLS_BRANCH: begin
            if (bus.Op[3]) begin
               isBranch   = 1'b1;
               bus.RegSrc = 2'b01;
               bus.ImmSrc = 2'b10;
               bus.ALUSrc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Branch condition evaluated against the stored flags. GT/LT/GE/LE are
   // the signed comparisons left behind by the previous COM.
   always_comb begin
      condEx = 1'b0;
      case (bus.Op[2:0])
         3'b000: condEx = 1'b1;
         3'b001: condEx = flagZ;
         3'b010: condEx = ~flagZ;
         3'b011: condEx = ~flagZ & (flagN == flagV);
         3'b100: condEx = (flagN != flagV);
         3'b101: condEx = (flagN == flagV);
         3'b110: condEx = flagZ | (flagN != flagV);
         default: condEx = 1'b0;
      endcase
   end

   assign bus.RegWrite = regWriteInt;

`ifdef CONTROLLER_PCWRITE_EN
   // A write-back to R15 acts as a computed jump.
   assign bus.PCSrc = (isBranch & condEx) | (regWriteInt & (bus.Rd == 4'hF));
   assign unusedBits = &{1'b0, flags[1]};
`else
   assign bus.PCSrc = isBranch & condEx;
   assign unusedBits = &{1'b0, flags[1], bus.Rd};
`endif

   // Only COM updates the flags. Branches and data writes leave them alone.
   // The carry bit is stored for completeness, although no condition tests it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flags <= 4'b0000;
      else if (flagW)
         flags <= bus.ALUFlags;
   end

endmodule

// File: tb/tb_asip_controller.sv
// tb_asip_controller
// Directed testbench for asip_controller. A behavioural model names each
// instruction, looks up its control row and tracks the NZCV flags that
// COM leaves behind. A compare process checks every output on each falling
// edge. Hand-computed literal checks pin the model to known values.
module tb_asip_controller;

   logic clk;
   logic reset;
   logic started;
   int   checks;
   int   passes;

   asip_controller_if bus ();

   asip_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {K_SUM, K_RST, K_COM, K_NOPD, K_GEM, K_CDM, K_BR, K_NONE} kind_t;

   logic [3:0] modelFlags;

   // Names the instruction from the fields the ISA defines for its class.
   function automatic kind_t kindOf(logic [5:0] op);
      if (op[5:4] === 2'b00) begin
         if (op[2:1] === 2'b00) return K_SUM;
         if (op[2:1] === 2'b01) return K_RST;
         if (op[2:1] === 2'b10) return K_COM;
         return K_NOPD;
      end
      if (op[5:4] === 2'b01) return (op[1] === 1'b1) ? K_CDM : K_GEM;
      if (op[5:4] === 2'b10 && op[3] === 1'b1) return K_BR;
      return K_NONE;
   endfunction

   // Expected output vector:
   // {RegSrc[1:0], RegWrite, ImmSrc[1:0], ALUSrc, ALUControl[1:0], MemWrite, MemtoReg, PCSrc}.
   function automatic logic [10:0] modelOut(logic [5:0] op, logic [3:0] rd, logic [3:0] f);
      bit n, z, v;
      bit taken [8];
      logic [10:0] row;
      n = f[3];
      z = f[2];
      v = f[0];
      taken = '{1'b1, z, !z, !z && (n == v), n != v, n == v, z || (n != v), 1'b0};
      case (kindOf(op))
         K_SUM:  row = {2'b00, 1'b1, 2'b00, op[3], 2'b00, 1'b0, 1'b0, 1'b0};
         K_RST:  row = {2'b00, 1'b1, 2'b00, op[3], 2'b01, 1'b0, 1'b0, 1'b0};
         K_COM:  row = {2'b00, 1'b0, 2'b00, op[3], 2'b01, 1'b0, 1'b0, 1'b0};
         K_NOPD: row = {2'b00, 1'b0, 2'b00, op[3], 2'b00, 1'b0, 1'b0, 1'b0};
         K_GEM:  row = {2'b10, 1'b0, 2'b01, 1'b1,  2'b00, 1'b1, 1'b0, 1'b0};
         K_CDM:  row = {2'b00, 1'b1, 2'b01, 1'b1,  2'b00, 1'b0, 1'b1, 1'b0};
         K_BR:   row = {2'b01, 1'b0, 2'b10, 1'b1,  2'b00, 1'b0, 1'b0, taken[op[2:0]]};
         default: row = 11'b0;
      endcase
`ifdef CONTROLLER_PCWRITE_EN
      if (row[8] && rd == 4'hF) row[0] = 1'b1;
`else
      if (rd === 4'hx) row = row;
`endif
      return row;
   endfunction

   // Reference flag register: COM captures ALUFlags, and reset clears the flags at any time.
   always @(posedge clk or posedge reset) begin
      if (reset)
         modelFlags <= 4'b0000;
      else if (kindOf(bus.Op) == K_COM)
         modelFlags <= bus.ALUFlags;
   end

   function automatic logic [10:0] dutVec();
      return {bus.RegSrc, bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.ALUControl,
              bus.MemWrite, bus.MemtoReg, bus.PCSrc};
   endfunction

   task automatic checkOutput(string name, logic [10:0] actual, logic [10:0] expected);
      checks++;
      if (actual === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, actual, expected, $time);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (started && !reset)
         checkOutput("cycle", dutVec(), modelOut(bus.Op, bus.Rd, modelFlags));
   end

   task automatic applyStimulus(logic [5:0] op, logic [3:0] rd, logic [3:0] aluFlags);
      @(posedge clk);
      #2;
      bus.Op       = op;
      bus.Rd       = rd;
      bus.ALUFlags = aluFlags;
      #1;
   endtask

   localparam logic [5:0] OP_SUM   = 6'b000000;
   localparam logic [5:0] OP_RST   = 6'b000010;
   localparam logic [5:0] OP_RSTI  = 6'b001010;
   localparam logic [5:0] OP_COM   = 6'b000100;
   localparam logic [5:0] OP_GEM   = 6'b010000;
   localparam logic [5:0] OP_CDM   = 6'b010010;
   localparam logic [5:0] OP_AL    = 6'b101000;
   localparam logic [5:0] OP_EQ    = 6'b101001;
   localparam logic [5:0] OP_NE    = 6'b101010;
   localparam logic [5:0] OP_GT    = 6'b101011;
   localparam logic [5:0] OP_SMEI  = 6'b101100;
   localparam logic [5:0] OP_SMAI  = 6'b101101;
   localparam logic [5:0] OP_LE    = 6'b101110;
   localparam logic [5:0] OP_NV    = 6'b101111;

   initial begin
      checks       = 0;
      passes       = 0;
      started      = 1'b0;
      reset        = 1'b1;
      bus.Op       = 6'b0;
      bus.Rd       = 4'h0;
      bus.ALUFlags = 4'h0;
      #12;
      reset   = 1'b0;
      started = 1'b1;

      // Reset state: flags 0000, which makes GE/NE/GT/AL taken and LT/EQ/LE/never not taken.
      applyStimulus(OP_SMAI, 4'h0, 4'h0);
      checkOutput("reset_smai_pcsrc", {10'b0, bus.PCSrc}, 11'd1);
      applyStimulus(OP_SMEI, 4'h0, 4'h0);
      checkOutput("reset_smei_pcsrc", {10'b0, bus.PCSrc}, 11'd0);
      applyStimulus(OP_EQ, 4'h0, 4'h0);
      checkOutput("reset_eq", {10'b0, bus.PCSrc}, 11'd0);
      applyStimulus(OP_NE, 4'h0, 4'h0);
      checkOutput("reset_ne_full", dutVec(), 11'b01_0_10_1_00_0_0_1);
      applyStimulus(OP_GT, 4'h0, 4'h0);
      applyStimulus(OP_LE, 4'h0, 4'h0);
      applyStimulus(OP_AL, 4'h0, 4'h0);
      applyStimulus(OP_NV, 4'h0, 4'h0);

      // Data instructions.
      applyStimulus(OP_SUM, 4'h1, 4'h0);
      checkOutput("sum_full", dutVec(), 11'b00_1_00_0_00_0_0_0);
      applyStimulus(OP_RST, 4'h2, 4'h0);
      checkOutput("rst_full", dutVec(), 11'b00_1_00_0_01_0_0_0);
      applyStimulus(OP_RSTI, 4'h2, 4'h0);
      checkOutput("rsti_full", dutVec(), 11'b00_1_00_1_01_0_0_0);
      applyStimulus(6'b000110, 4'hF, 4'h0);
      checkOutput("data_cmd11", dutVec(), 11'b0);
      applyStimulus(6'b00000x, 4'h3, 4'h0);
      checkOutput("sum_xbit", dutVec(), 11'b00_1_00_0_00_0_0_0);

      // COM with N set, V clear: LT is taken and GE is not.
      applyStimulus(OP_COM, 4'h0, 4'b1000);
      checkOutput("com_full", dutVec(), 11'b00_0_00_0_01_0_0_0);
      applyStimulus(OP_SMEI, 4'h0, 4'b0000);
      checkOutput("com_smei_pcsrc", {10'b0, bus.PCSrc}, 11'd1);
      applyStimulus(OP_SMAI, 4'h0, 4'b0000);
      checkOutput("com_smai_pcsrc", {10'b0, bus.PCSrc}, 11'd0);

      // Memory instructions.
      applyStimulus(OP_GEM, 4'h4, 4'h0);
      checkOutput("gem_full", dutVec(), 11'b10_0_01_1_00_1_0_0);
      applyStimulus(OP_CDM, 4'h4, 4'h0);
      checkOutput("cdm_full", dutVec(), 11'b00_1_01_1_00_0_1_0);

      // Write to R15.
      applyStimulus(OP_SUM, 4'hF, 4'h0);
`ifdef CONTROLLER_PCWRITE_EN
      checkOutput("sum_r15_pcsrc", {10'b0, bus.PCSrc}, 11'd1);
`else
      checkOutput("sum_r15_pcsrc", {10'b0, bus.PCSrc}, 11'd0);
`endif
      applyStimulus(OP_CDM, 4'hF, 4'h0);

      // Z flag set: EQ and LE are taken; NE and GT are not. Rd is x on COM.
      applyStimulus(OP_COM, 4'bxxxx, 4'b0100);
      applyStimulus(OP_EQ, 4'h0, 4'h0);
      checkOutput("z_eq", {10'b0, bus.PCSrc}, 11'd1);
      applyStimulus(OP_NE, 4'h0, 4'h0);
      applyStimulus(OP_GT, 4'h0, 4'h0);
      applyStimulus(OP_LE, 4'h0, 4'h0);

      // N and V both set: GE and GT are taken.
      applyStimulus(OP_COM, 4'h0, 4'b1001);
      applyStimulus(OP_GT, 4'h0, 4'h0);
      checkOutput("nv_gt", {10'b0, bus.PCSrc}, 11'd1);
      applyStimulus(OP_SMEI, 4'h0, 4'h0);

      // Branches never write flags: a branch cycle with ALUFlags=1000 is ignored.
      applyStimulus(OP_AL, 4'h0, 4'b1000);
      applyStimulus(OP_SMAI, 4'h0, 4'h0);
      checkOutput("branch_keeps_flags", {10'b0, bus.PCSrc}, 11'd1);

      // Reserved encodings.
      applyStimulus(6'b110101, 4'hF, 4'h0);
      checkOutput("class11", dutVec(), 11'b0);
      applyStimulus(6'b100101, 4'h0, 4'h0);
      checkOutput("branch_op3_zero", dutVec(), 11'b0);

      // Mid-cycle reset between COM and the branch.
      applyStimulus(OP_COM, 4'h0, 4'b1000);
      applyStimulus(OP_SMAI, 4'h0, 4'h0);
      checkOutput("pre_reset_smai", {10'b0, bus.PCSrc}, 11'd0);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      checkOutput("post_reset_smai", {10'b0, bus.PCSrc}, 11'd1);
      applyStimulus(OP_SMEI, 4'h0, 4'h0);

      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
